rv32i_trace_capture: RTL

Retirement-trace consumer for the single-cycle RV32I core. It samples the core's commit/trace outputs (PC, instruction, register write-back, data-memory access) every retiring cycle and packs each retirement into a fixed 13-byte record. Records are buffered in a small FIFO and drained as a byte stream over a valid/ready handshake toward a UART or debug bridge. It sits beside `rv32i_top`, wired to its `pc_o`/`instr_o`/`reg_*_o`/`mem_*_o` ports.

---
 rtl/rv32i_trace_capture_pkg.sv | 35 +++
 rtl/rv32i_trace_capture_if.sv | 9 +
 rtl/rv32i_trace_fifo.sv | 39 +++
 rtl/rv32i_trace_capture.sv | 87 ++++++++
 4 files changed

// File: rtl/rv32i_trace_capture_pkg.sv
// rv32i_trace_pkg: record layout, header bit positions and serializer states shared by the trace capture block.
package rv32i_trace_pkg;

    localparam int REC_BYTES    = 13;
    localparam int REC_BITS     = 8 * REC_BYTES;
    localparam int HDR_SYNC     = 7;
    localparam int HDR_WRT      = 6;
    localparam int HDR_READ     = 5;
    localparam int HDR_REG_MSB  = 4;
    localparam logic SYNC_BIT   = 1'b1;

    // Field order puts the header in the low byte, followed by pc/instr/value,
    // so shifting right by 8 walks the record in little-endian stream order.
    typedef struct packed {
        logic [31:0] value;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  hdr;
    } trace_rec_t;

    typedef enum logic {IDLE, SEND} trace_state_t;

    function automatic trace_rec_t pack_rec(input logic wrt, input logic rd, input logic [4:0] rd_addr,
                                            input logic [31:0] pc, input logic [31:0] instr,
                                            input logic [31:0] reg_data, input logic [31:0] mem_data);
        logic [7:0] h;
        h = '0;
        h[HDR_SYNC] = SYNC_BIT;
        h[HDR_WRT] = wrt;
        h[HDR_READ] = rd;
        h[HDR_REG_MSB:0] = rd_addr;
        return '{value: wrt ? mem_data : reg_data, instr: instr, pc: pc, hdr: h};
    endfunction

endpackage

// File: rtl/rv32i_trace_capture_if.sv
// rv32i_trace_capture_if: valid/ready byte stream from the trace capture toward a UART or debug bridge.
interface rv32i_trace_capture_if;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       byte_ready_i;

    modport master (output byte_o, output byte_valid_o, input byte_ready_i);
    modport slave  (input byte_o, input byte_valid_o, output byte_ready_i);
endinterface

// File: rtl/rv32i_trace_fifo.sv
// rv32i_trace_fifo: DEPTH x 104-bit record FIFO, extra-bit pointers, push and pop allowed on the same edge.
module rv32i_trace_fifo
    import rv32i_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push,
    input  logic       pop,
    input  trace_rec_t wr_rec,
    output trace_rec_t rd_rec,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    trace_rec_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign rd_rec = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop) rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_rec;
    end
endmodule

// File: rtl/rv32i_trace_capture.sv
// rv32i_trace_capture: packs each RV32I retirement into a 13-byte record, buffers it and streams it bytewise.
// Build option TRACE_FILTER_EN: keep only retirements that write a register or store to memory.
module rv32i_trace_capture
    import rv32i_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  retire_i,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           instr_i,
    input  logic [4:0]            reg_addr_i,
    input  logic [31:0]           reg_data_i,
    input  logic [31:0]           mem_data_i,
    input  logic                  mem_wrt_i,
    input  logic                  mem_read_i,
    rv32i_trace_capture_if.master bus,
    output logic                  busy_o,
    output logic [15:0]           dropped_o
);
    localparam logic [3:0] LAST_IDX = 4'(REC_BYTES - 1);

    trace_state_t state_q, state_nx;
    logic [REC_BITS-1:0] hold_q, hold_nx;
    logic [3:0] idx_q, idx_nx;
    logic push_req, push, pop, full, empty, xfer;
    trace_rec_t rec, head;

`ifdef TRACE_FILTER_EN
    assign push_req = retire_i && (reg_addr_i != 5'd0 || mem_wrt_i);
`else
    assign push_req = retire_i;
`endif

    assign rec = pack_rec(mem_wrt_i, mem_read_i, reg_addr_i, pc_i, instr_i, reg_data_i, mem_data_i);
    assign push = push_req && (!full || pop);
    assign xfer = bus.byte_valid_o && bus.byte_ready_i;
    assign bus.byte_valid_o = state_q == SEND;
    assign bus.byte_o = hold_q[7:0];
    assign busy_o = (state_q == SEND) || !empty;

    rv32i_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .wr_rec (rec),
        .rd_rec (head),
        .full   (full),
        .empty  (empty)
    );

    // Loading happens from IDLE or on the last byte's transfer, so records run back to back.
    always_comb begin
        state_nx = state_q;
        idx_nx = idx_q;
        hold_nx = hold_q;
        pop = 1'b0;
        if (state_q == IDLE || (xfer && idx_q == LAST_IDX)) begin
            pop = !empty;
            state_nx = empty ? IDLE : SEND;
            idx_nx = '0;
            hold_nx = empty ? hold_q >> 8 : REC_BITS'(head);
        end else if (xfer) begin
            idx_nx = idx_q + 4'd1;
            hold_nx = hold_q >> 8;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q <= '0;
            hold_q <= '0;
        end else begin
            state_q <= state_nx;
            idx_q <= idx_nx;
            hold_q <= hold_nx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dropped_o <= '0;
        else if (push_req && full && !pop && dropped_o != 16'hFFFF) dropped_o <= dropped_o + 16'd1;
    end
endmodule
